// File: rtl/pixel_result_queue_if.sv
// Stream bundle between the iteration engine, the pixel result queue and
// the frame-buffer writer. The queue takes the slave modport; whoever drives
// pixel results and consumes the RGB stream takes the master modport.
interface pixel_result_queue_if #(
   parameter int DEPTH  = 8,
   parameter int ITER_W = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic [ITER_W-1:0] in_iter;
   logic              in_escaped;
   logic              full_queue;
   logic [23:0]       out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_sof;
   logic              out_eol;
   logic              overflow;
   logic [LW-1:0]     level;

   modport master (
      output in_valid, in_iter, in_escaped, out_ready,
      input  full_queue, out_data, out_valid, out_sof, out_eol, overflow, level
   );

   modport slave (
      input  in_valid, in_iter, in_escaped, out_ready,
      output full_queue, out_data, out_valid, out_sof, out_eol, overflow, level
   );
endinterface

// File: rtl/pixel_result_queue.sv
// Pixel result queue: maps escape results to RGB on write, buffers them in a
// circular FIFO with first-word fall-through, and tags the output stream
// with start-of-frame / end-of-line markers.
// Optional build macro PIXEL_RESULT_QUEUE_COLOUR_MAP_EN selects pseudo-colour
// bands instead of greyscale for escaped pixels.
module pixel_result_queue #(
   parameter int DEPTH  = 8,
   parameter int ITER_W = 8,
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic                  clk,
   input  logic                  rst,
   pixel_result_queue_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   logic [23:0]   mem_q [DEPTH];
   logic [AW-1:0] rp_q, rp_d;
   logic [AW-1:0] wp_q, wp_d;
   logic [LW-1:0] level_q, level_d;
   logic          ovf_q, ovf_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          out_valid;
   logic          rd_en;
   logic          wr_en;
   logic          is_full;

   // Colour mapping: inside-set pixels are black; escaped pixels use the top
   // eight bits of the iteration count.
   function automatic logic [23:0] map_colour(input logic escaped,
                                              input logic [ITER_W-1:0] iter);
      logic [7:0] c;
      c = iter[ITER_W-1 -: 8];
      if (!escaped) begin
         return 24'h000000;
      end
`ifdef PIXEL_RESULT_QUEUE_COLOUR_MAP_EN
      return {c, 8'(c << 1), 8'(c << 2)};
`else
      return {c, c, c};
`endif
   endfunction

   assign out_valid = (level_q != '0);
   assign is_full   = (level_q == LW'(DEPTH));
   assign rd_en     = out_valid && bus.out_ready;
   // A read in the same cycle frees the slot, so a full queue still accepts.
   assign wr_en     = bus.in_valid && (!is_full || rd_en);

   // Next-state for pointers, occupancy, sticky overflow and pixel counters.
   always_comb begin
      rp_d    = rp_q;
      wp_d    = wp_q;
      level_d = level_q;
      ovf_d   = ovf_q;
      x_d     = x_q;
      y_d     = y_q;
      if (bus.in_valid && !wr_en) begin
         ovf_d = 1'b1;
      end
      if (wr_en) begin
         wp_d = wp_q + AW'(1);
      end
      if (rd_en) begin
         rp_d = rp_q + AW'(1);
         if (x_q == XW'(WIDTH - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(HEIGHT - 1)) ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Control state register; reset discards queued pixels and restarts the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         rp_q    <= '0;
         wp_q    <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         rp_q    <= rp_d;
         wp_q    <= wp_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // FIFO storage holds final pixel words; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wp_q] <= map_colour(bus.in_escaped, bus.in_iter);
      end
   end

   assign bus.out_data   = mem_q[rp_q];
   assign bus.out_valid  = out_valid;
   assign bus.out_sof    = (x_q == '0) && (y_q == '0);
   assign bus.out_eol    = (x_q == XW'(WIDTH - 1));
   assign bus.overflow   = ovf_q;
   assign bus.level      = level_q;
   // Registered-only decode leaves one spare slot for the engine's in-flight write.
   assign bus.full_queue = (level_q >= LW'(DEPTH - 1));
endmodule

// File: tb/tb_pixel_result_queue.sv
// Directed bench for pixel_result_queue with a queue-based reference model
// and a per-cycle compare process.
module tb_pixel_result_queue;
   localparam int DEPTH  = 8;
   localparam int ITER_W = 8;
   localparam int W      = 5;
   localparam int H      = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pixel_result_queue_if #(.DEPTH(DEPTH), .ITER_W(ITER_W)) bus ();

   pixel_result_queue #(.DEPTH(DEPTH), .ITER_W(ITER_W), .WIDTH(W), .HEIGHT(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [23:0] exp_colour(input logic esc, input logic [7:0] it);
      int c;
      c = it;
      if (!esc) return 24'h0;
`ifdef PIXEL_RESULT_QUEUE_COLOUR_MAP_EN
      return 24'((c << 16) | (((c * 2) % 256) << 8) | ((c * 4) % 256));
`else
      return 24'(c * 32'h010101);
`endif
   endfunction

   // Reference model: a queue of words, a sticky flag and a linear pixel index.
   logic [23:0] m_q[$];
   bit          m_ovf = 1'b0;
   int          m_pix = 0;

   always @(posedge clk) begin
      bit rd, wr;
      if (rst) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_pix = 0;
      end else begin
         rd = (m_q.size() > 0) && bus.out_ready;
         wr = bus.in_valid && ((m_q.size() < DEPTH) || rd);
         if (bus.in_valid && !wr) m_ovf = 1'b1;
         if (rd) begin
            void'(m_q.pop_front());
            m_pix = (m_pix + 1) % (W * H);
         end
         if (wr) m_q.push_back(exp_colour(bus.in_escaped, bus.in_iter));
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
         check("m_level", 32'(bus.level), 32'(m_q.size()));
         check("m_full", 32'(bus.full_queue), 32'(m_q.size() >= DEPTH - 1));
         check("m_ovf", 32'(bus.overflow), 32'(m_ovf));
         if (m_q.size() > 0) begin
            check("m_data", 32'(bus.out_data), 32'(m_q[0]));
            check("m_sof", 32'(bus.out_sof), 32'(m_pix == 0));
            check("m_eol", 32'(bus.out_eol), 32'((m_pix % W) == W - 1));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   logic [23:0] lit_10, lit_11, lit_aa;
   int n_valid, n_sof, n_eol, max_lvl;

   initial begin
`ifdef PIXEL_RESULT_QUEUE_COLOUR_MAP_EN
      lit_10 = 24'h102040; lit_11 = 24'h112244; lit_aa = 24'hAA54A8;
`else
      lit_10 = 24'h101010; lit_11 = 24'h111111; lit_aa = 24'hAAAAAA;
`endif
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_iter = '0; bus.in_escaped = 1'b0; bus.out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_level", 32'(bus.level), 0);
      check("rst_full", 32'(bus.full_queue), 0);
      check("rst_ovf", 32'(bus.overflow), 0);
      check("rst_sof", 32'(bus.out_sof), 1);
      check("rst_eol", 32'(bus.out_eol), 0);

      // Single write, fall-through after one edge
      bus.in_valid = 1'b1; bus.in_iter = 8'h10; bus.in_escaped = 1'b1; bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("first_valid", 32'(bus.out_valid), 1);
      check("first_sof", 32'(bus.out_sof), 1);
      check("first_data", 32'(bus.out_data), 32'(lit_10));
      tick();
      check("first_level0", 32'(bus.level), 0);

      // Fill to full with output stalled
      bus.out_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = 1'b1; bus.in_iter = 8'(i * 16 + 1); bus.in_escaped = 1'b1;
         tick();
         if (i == 5) check("full_at6", 32'(bus.full_queue), 0);
      end
      check("full_at7", 32'(bus.full_queue), 1);
      check("level7", 32'(bus.level), 7);
      bus.in_iter = 8'h77;
      tick();
      check("level8", 32'(bus.level), 8);
      check("ovf_at8", 32'(bus.overflow), 0);
      // Simultaneous read and write while full
      bus.in_iter = 8'hAA; bus.out_ready = 1'b1;
      tick();
      check("rw_level", 32'(bus.level), 8);
      check("rw_ovf", 32'(bus.overflow), 0);
      // Write into a full queue with no read is dropped
      bus.in_iter = 8'h55; bus.out_ready = 1'b0;
      tick();
      check("drop_ovf", 32'(bus.overflow), 1);
      check("drop_level", 32'(bus.level), 8);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) check("drain_first", 32'(bus.out_data), 32'(lit_11));
         if (k == 7) check("drain_last", 32'(bus.out_data), 32'(lit_aa));
         tick();
      end
      check("drain_level", 32'(bus.level), 0);

      // Inside-set pixel is black
      bus.in_valid = 1'b1; bus.in_iter = 8'hFF; bus.in_escaped = 1'b0; bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      check("black", 32'(bus.out_data), 0);
      bus.out_ready = 1'b1;
      tick();

      // Full-frame stream plus one pixel
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_ovf", 32'(bus.overflow), 0);
      n_valid = 0; n_sof = 0; n_eol = 0; max_lvl = 0;
      for (int i = 0; i < W * H + 3; i++) begin
         if (bus.out_valid === 1'b1) begin
            n_valid++;
            if (bus.out_sof === 1'b1) n_sof++;
            if (bus.out_eol === 1'b1) n_eol++;
         end
         if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
         bus.in_valid = (i < W * H + 1); bus.in_iter = 8'(i); bus.in_escaped = 1'b1;
         tick();
      end
      check("stream_cnt", 32'(n_valid), W * H + 1);
      check("stream_sof", 32'(n_sof), 2);
      check("stream_eol", 32'(n_eol), H);
      check("stream_maxlvl", 32'(max_lvl), 1);

      // Reset mid-stream with x=3 and 5 queued entries
      rst = 1'b1; bus.in_valid = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1; bus.in_iter = 8'(i + 3);
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1; bus.in_iter = 8'(i + 40);
         tick();
      end
      check("pre_rst_level", 32'(bus.level), 5);
      check("pre_rst_sof", 32'(bus.out_sof), 0);
      bus.in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_valid", 32'(bus.out_valid), 0);
      check("mid_level", 32'(bus.level), 0);
      check("mid_full", 32'(bus.full_queue), 0);
      check("mid_ovf", 32'(bus.overflow), 0);
      bus.in_valid = 1'b1; bus.in_iter = 8'h20; bus.in_escaped = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("mid_next_valid", 32'(bus.out_valid), 1);
      check("mid_next_sof", 32'(bus.out_sof), 1);
      bus.out_ready = 1'b1;
      tick(); tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/pixel_result_queue.md
# pixel_result_queue

Buffers per-pixel escape results from the iteration engine and streams them out as 24-bit RGB video with frame and line markers. Sits directly downstream of the iteration-engine state machine: its `full_queue` output throttles that state machine, and its stream output feeds the frame-buffer/VGA writer. Colour mapping happens on write, so the FIFO stores final pixel words.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 4.
- `ITER_W`, 8: iteration-count width; at least 8.
- `WIDTH`, 640: pixels per line.
- `HEIGHT`, 480: lines per frame.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `in_valid` in 1: one pixel result presented this cycle.
- `in_iter` in ITER_W: iteration count at escape.
- `in_escaped` in 1: 1 = escaped; 0 = hit max iterations (inside set).
- `full_queue` out 1: throttle to the engine.
- `out_data` out 24: pixel {R,G,B}, 8 bits each.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: downstream accepts.
- `out_sof` out 1: current output pixel is (0,0).
- `out_eol` out 1: current output pixel is the last in its line.
- `overflow` out 1: sticky; a write was attempted while the FIFO held DEPTH entries.
- `level` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Circular FIFO with read pointer `rp`, write pointer `wp` and a registered `level`; pointers wrap modulo DEPTH.
- Write: accepted when `in_valid` and `level < DEPTH`. The mapped colour is stored at `wp`, then `wp` increments.
- Write while `level == DEPTH`: the data is dropped, `overflow` is set, and it stays set until `rst`.
- Read: occurs when `out_valid && out_ready`; `rp` increments.
- Simultaneous read and write: `level` is unchanged. Both are legal at `level == DEPTH`, since the read frees the slot; in that case `overflow` is not set.
- `full_queue = (level >= DEPTH-1)`, decoded from the `level` register only; there is no combinational path from inputs. The one spare slot absorbs the write already in flight when the engine sees `full_queue`.
- Output pixel counters `x` (0..WIDTH-1) and `y` (0..HEIGHT-1) advance on each read.
  - `x` wraps to 0 at WIDTH-1, and `y` then increments.
  - `y` wraps to 0 at HEIGHT-1, which completes the frame.
- `out_sof = (x==0 && y==0)`; `out_eol = (x==WIDTH-1)`. Both are meaningful only while `out_valid` is high.
- Colour uses `c = in_iter[ITER_W-1 -: 8]`.
  - `in_escaped == 0` gives 0x000000 in every configuration.
  - For escaped pixels, see Configuration.
- Reset values:
  - `rp`, `wp`, `level`, `x`, `y` = 0.
  - `overflow` = 0; `out_valid` = 0; `full_queue` = 0.
  - `out_sof` = 1; `out_eol` = 0 (combinational from the counters).
  - FIFO contents are not reset.
- Reset mid-stream: all queued pixels are discarded and the counters return to (0,0). The next pixel written is treated as the start of a frame.

## Timing
- First-word fall-through: a write accepted at edge N gives `out_valid = 1` with that data after edge N, for 1-cycle latency. There is no same-cycle bypass when empty.
- `out_data`, `out_sof` and `out_eol` are held stable while `out_valid && !out_ready`.
- `full_queue` rises on the edge at which `level` reaches DEPTH-1, and falls on the edge at which `level` drops below DEPTH-1.
- With `out_ready` held high and one write per cycle, throughput is 1 pixel/cycle and `level` never exceeds 1.

## Configuration
- `PIXEL_RESULT_QUEUE_COLOUR_MAP_EN` defined: escaped pixel = {c, c<<1, c<<2}, each truncated to 8 bits (pseudo-colour bands).
- Not defined: escaped pixel = {c, c, c} (greyscale).
- The inside-set black and all timing are identical in both builds.

## Test plan
- Reset, then 1 write with `in_iter=0x10`, `in_escaped=1`, `out_ready=1` → next cycle: `out_valid=1`, `out_sof=1`, `out_data=0x102040` (macro on) or 0x101010 (macro off); `level` returns to 0.
- `out_ready=0`, 7 writes with DEPTH=8 → `full_queue=1` after the 7th edge. An 8th write is accepted with `level=8` and `overflow=0`. A 9th write sets `overflow=1` and is dropped; the 8 stored words drain in order.
- `level=8`, simultaneous read and write → `level` stays 8, `overflow=0`, and the written word is read out last.
- Stream WIDTH×HEIGHT pixels with `out_ready=1` → `out_eol` every WIDTH-th pixel. `out_sof` only on pixel 0, then again on pixel WIDTH·HEIGHT, confirming the wrap.
- `in_escaped=0`, `in_iter=0xFF` → `out_data=0x000000`.
- Assert `rst` with 5 queued entries and x=3 → after the reset edge: `out_valid=0`, `level=0`, `full_queue=0`, `overflow=0`. The next written pixel emerges with `out_sof=1`.
